decoder_logic_pipe: RTL

Parametrised, pipelined logic-function unit built on an N-to-2^N one-hot decoder. Each accepted N-bit operand is decoded to a one-hot minterm vector, and the selected function is formed by OR-ing the minterms in its on-set. The functions are XOR, XNOR, AND, NAND, OR, NOR, or a programmable truth table. It sits behind a valid/ready stream as the general-purpose successor to the fixed 2-input decoder-based XOR/XNOR gate.

---
 rtl/decoder_logic_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/decoder_logic_pipe.sv
// Pipelined logic-function unit: an N-to-2^N one-hot decoder feeds an OR of on-set
// minterms selected by op, behind a two-stage stall-all valid/ready pipeline.
module decoder_logic_pipe #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    input  logic [2:0]            in_op,
    input  logic                  cfg_we,
    input  logic [(1<<N)-1:0]     cfg_lut,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_y,
    output logic [(1<<N)-1:0]     out_onehot,
    output logic [CNT_W-1:0]      ones_cnt
);

    localparam int unsigned M = 1 << N;

    typedef enum logic [2:0] {
        OP_XOR  = 3'b000,
        OP_XNOR = 3'b001,
        OP_AND  = 3'b010,
        OP_NAND = 3'b011,
        OP_OR   = 3'b100,
        OP_NOR  = 3'b101,
        OP_LUT  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // Minterms whose index has odd popcount form the XOR on-set.
    function automatic logic [M-1:0] odd_mask();
        logic [M-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < M; k++) begin
            m[k] = ^(N'(k));
        end
        return m;
    endfunction

    localparam logic [M-1:0] ODD_SET = odd_mask();
    localparam logic [M-1:0] TOP_SET = M'(1) << (M - 1);
    localparam logic [M-1:0] ZERO_SET = M'(1);

    logic           advance;
    logic [M-1:0]   dec;
    logic [M-1:0]   lut_q;

    logic           s1_valid;
    logic [M-1:0]   s1_onehot;
    op_e            s1_op;
    logic [M-1:0]   s1_lut;

    logic [M-1:0]   onset;
    logic           y_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign dec      = M'(1) << in_data;

    always_comb begin
        onset = '0;
        unique case (s1_op)
            OP_XOR:  onset = ODD_SET;
            OP_XNOR: onset = ~ODD_SET;
            OP_AND:  onset = TOP_SET;
            OP_NAND: onset = ~TOP_SET;
            OP_OR:   onset = ~ZERO_SET;
            OP_NOR:  onset = ZERO_SET;
            OP_LUT:  onset = s1_lut;
            OP_RSVD: onset = '0;
        endcase
    end

    assign y_next = |(s1_onehot & onset);

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q <= '0;
        end else if (cfg_we) begin
            lut_q <= cfg_lut;
        end
    end

    // Bubbles carry a cleared onehot so out_y and out_onehot read zero when not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_onehot  <= '0;
            s1_op      <= OP_XOR;
            s1_lut     <= '0;
            out_valid  <= 1'b0;
            out_y      <= 1'b0;
            out_onehot <= '0;
        end else if (advance) begin
            s1_valid   <= in_valid;
            s1_onehot  <= in_valid ? dec : '0;
            s1_op      <= op_e'(in_op);
            s1_lut     <= lut_q;
            out_valid  <= s1_valid;
            out_y      <= y_next;
            out_onehot <= s1_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (out_valid && out_ready && out_y && (ones_cnt != '1)) begin
            ones_cnt <= ones_cnt + CNT_W'(1);
        end
    end

endmodule
